// File: rtl/mig_ui_responder_if.sv
// App-side channel bundle of the DDR3 UI stand-in.
// master = traffic generator, slave = responder.
interface mig_ui_responder_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [127:0] app_wdf_data;
  logic         app_wdf_end;
  logic         app_wdf_wren;
  logic [15:0]  app_wdf_mask;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_end;
  logic         app_rd_data_valid;
  logic         init_calib_complete;
  logic         app_sr_req;
  logic         app_ref_req;
  logic         app_zq_req;
  logic         app_sr_active;
  logic         app_ref_ack;
  logic         app_zq_ack;

  modport master (
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_end,
    output app_wdf_wren, app_wdf_mask,
    output app_sr_req, app_ref_req, app_zq_req,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_end,
    input  app_rd_data_valid,
    input  init_calib_complete,
    input  app_sr_active, app_ref_ack, app_zq_ack
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_end,
    input  app_wdf_wren, app_wdf_mask,
    input  app_sr_req, app_ref_req, app_zq_req,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_end,
    output app_rd_data_valid,
    output init_calib_complete,
    output app_sr_active, app_ref_ack, app_zq_ack
  );
endinterface

// File: rtl/mig_ui_responder.sv
// BRAM-backed responder for the DDR3 UI app_* channels:
// calibration delay, stall injection, write pairing, fixed-latency reads.
module mig_ui_responder #(
  parameter int DEPTH_WORDS  = 4096,
  parameter int ADDR_LSB     = 3,
  parameter int CALIB_CYCLES = 16,
  parameter int RD_LATENCY   = 4,
  parameter int RDY_PERIOD   = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  mig_ui_responder_if.slave app,
  output logic        err_out,
  output logic [31:0] wr_count_out,
  output logic [31:0] rd_count_out
);
  localparam int IW = 27 - ADDR_LSB;
  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int SW = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
  localparam bit STALL_EN = (RDY_PERIOD >= 2);
  localparam logic [SW-1:0] STALL_AT =
    SW'((RDY_PERIOD > 1) ? RDY_PERIOD - 1 : 0);

  logic [CW-1:0]  r_cal_cnt;
  logic           r_calib;
  logic [SW-1:0]  r_stall_cnt;
  logic           r_wcmd_pend;
  logic [IW-1:0]  r_wcmd_idx;
  logic           r_wdata_held;
  logic [127:0]   r_wdata;
  logic [15:0]    r_wmask;
  logic [127:0]   r_mem [DEPTH_WORDS];
  logic [RD_LATENCY-1:0] r_pvld;
  logic [127:0]   r_pdata [RD_LATENCY];

  logic           w_stall;
  logic           w_rdy;
  logic           w_wdf_rdy;
  logic [IW-1:0]  w_idx_new;
  logic           w_rd_rng;
  logic           w_cmd_acc;
  logic           w_is_wr;
  logic           w_is_rd;
  logic           w_wcmd_new;
  logic           w_rcmd;
  logic           w_bad_cmd;
  logic           w_dat_acc;
  logic           w_commit;
  logic [IW-1:0]  w_c_idx;
  logic [127:0]   w_c_data;
  logic [15:0]    w_c_mask;
  logic           w_c_rng;
  logic           w_err_set;
  logic           w_unused;

  assign w_stall   = STALL_EN && (r_stall_cnt == STALL_AT);
  assign w_rdy     = r_calib & ~w_stall & ~r_wcmd_pend;
  assign w_wdf_rdy = r_calib & ~w_stall & ~r_wdata_held;

  assign w_idx_new = app.app_addr[26:ADDR_LSB];
  assign w_rd_rng  = 32'(w_idx_new) < 32'(DEPTH_WORDS);
  assign w_cmd_acc = app.app_en & w_rdy;
  assign w_is_wr   = (app.app_cmd == 3'b000);
  assign w_is_rd   = (app.app_cmd == 3'b001);
  assign w_wcmd_new = w_cmd_acc & w_is_wr;
  assign w_rcmd    = w_cmd_acc & w_is_rd;
  assign w_bad_cmd = w_cmd_acc & ~w_is_wr & ~w_is_rd;
  assign w_dat_acc = app.app_wdf_wren & w_wdf_rdy;

  // A write commits once both halves exist, held or arriving now.
  assign w_commit = (r_wcmd_pend | w_wcmd_new)
                  & (r_wdata_held | w_dat_acc);
  assign w_c_idx  = r_wcmd_pend ? r_wcmd_idx : w_idx_new;
  assign w_c_data = r_wdata_held ? r_wdata : app.app_wdf_data;
  assign w_c_mask = r_wdata_held ? r_wmask : app.app_wdf_mask;
  assign w_c_rng  = 32'(w_c_idx) < 32'(DEPTH_WORDS);

  assign w_err_set = (w_dat_acc & ~app.app_wdf_end)
                   | w_bad_cmd
                   | (w_commit & ~w_c_rng)
                   | (w_rcmd & ~w_rd_rng);

  assign w_unused = ^{app.app_sr_req, app.app_ref_req,
                      app.app_zq_req, app.app_addr};

  assign app.app_rdy             = w_rdy;
  assign app.app_wdf_rdy         = w_wdf_rdy;
  assign app.app_rd_data_valid   = r_pvld[RD_LATENCY-1];
  assign app.app_rd_data_end     = r_pvld[RD_LATENCY-1];
  assign app.app_rd_data         = r_pvld[RD_LATENCY-1]
                                 ? r_pdata[RD_LATENCY-1] : '0;
  assign app.init_calib_complete = r_calib;
  assign app.app_sr_active       = 1'b0;
  assign app.app_ref_ack         = 1'b0;
  assign app.app_zq_ack          = 1'b0;

  // Calibration delay, then ready-stall phase counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cal_cnt   <= '0;
      r_calib     <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!r_calib) begin
      if (r_cal_cnt == CW'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
      else r_cal_cnt <= r_cal_cnt + 1'b1;
    end else begin
      if (STALL_EN && r_stall_cnt == STALL_AT) r_stall_cnt <= '0;
      else r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // One-entry holding registers for unpaired write command/data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wcmd_pend  <= 1'b0;
      r_wcmd_idx   <= '0;
      r_wdata_held <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_commit) begin
      r_wcmd_pend  <= 1'b0;
      r_wdata_held <= 1'b0;
    end else begin
      if (w_wcmd_new) begin
        r_wcmd_pend <= 1'b1;
        r_wcmd_idx  <= w_idx_new;
      end
      if (w_dat_acc) begin
        r_wdata_held <= 1'b1;
        r_wdata      <= app.app_wdf_data;
        r_wmask      <= app.app_wdf_mask;
      end
    end
  end

  // Byte-masked memory write, memory read and read data pipeline.
  always_ff @(posedge clk_in) begin
    if (w_commit && w_c_rng) begin
      for (int b = 0; b < 16; b++) begin
        if (!w_c_mask[b])
          r_mem[w_c_idx[MW-1:0]][b*8 +: 8] <= w_c_data[b*8 +: 8];
      end
    end
    r_pdata[0] <= w_rd_rng ? r_mem[w_idx_new[MW-1:0]] : '0;
    for (int i = 1; i < RD_LATENCY; i++)
      r_pdata[i] <= r_pdata[i-1];
  end

  // Read valid pipeline; reset drops reads in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pvld <= '0;
    end else begin
      r_pvld[0] <= w_rcmd;
      for (int i = 1; i < RD_LATENCY; i++)
        r_pvld[i] <= r_pvld[i-1];
    end
  end

  // Sticky error flag and transaction counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_out      <= 1'b0;
      wr_count_out <= '0;
      rd_count_out <= '0;
    end else begin
      if (w_err_set) err_out <= 1'b1;
      if (w_commit) wr_count_out <= wr_count_out + 1'b1;
      if (r_pvld[RD_LATENCY-1])
        rd_count_out <= rd_count_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_mig_ui_responder.sv
// Bench for mig_ui_responder: table vectors plus read scoreboard.
// dut0 never stalls, dut4 stalls one cycle in four.
module tb_mig_ui_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mig_ui_responder_if if0 ();
  mig_ui_responder_if if4 ();
  logic        err0, err4;
  logic [31:0] wc0, rc0, wc4, rc4;

  mig_ui_responder #(.RDY_PERIOD(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .app(if0.slave),
    .err_out(err0), .wr_count_out(wc0), .rd_count_out(rc0)
  );
  mig_ui_responder #(.RDY_PERIOD(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .app(if4.slave),
    .err_out(err4), .wr_count_out(wc4), .rd_count_out(rc4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] d;
    int           due;
  } rd_exp_t;
  rd_exp_t q0[$];
  rd_exp_t q4[$];
  rd_exp_t e0, e4;

  typedef struct {
    logic [26:0]  a;
    logic [127:0] d;
    logic [15:0]  m;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if0.app_rd_data_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexp: got valid at cyc %0d want none",
                 cyc);
      end else begin
        e0 = q0.pop_front();
        chk("rd0_data", if0.app_rd_data, e0.d);
        chk("rd0_lat", 128'(cyc), 128'(e0.due));
        chk("rd0_end", 128'(if0.app_rd_data_end), 128'(1));
      end
    end
  end

  always @(negedge clk) begin
    if (if4.app_rd_data_valid) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd4_unexp: got valid at cyc %0d want none",
                 cyc);
      end else begin
        e4 = q4.pop_front();
        chk("rd4_data", if4.app_rd_data, e4.d);
        chk("rd4_lat", 128'(cyc), 128'(e4.due));
      end
    end
  end

  function automatic logic [127:0] d4(int i);
    return {4{32'hBEEF0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(logic [26:0] a, logic [127:0] d,
                     logic [15:0] m);
    if0.app_addr = a; if0.app_cmd = 3'b000; if0.app_en = 1'b1;
    if0.app_wdf_data = d; if0.app_wdf_mask = m;
    if0.app_wdf_wren = 1'b1;
    chk("wr0_rdy", 128'({if0.app_rdy, if0.app_wdf_rdy}),
        128'(2'b11));
    tick();
    if0.app_en = 1'b0; if0.app_wdf_wren = 1'b0;
  endtask

  task automatic rd0(logic [26:0] a, logic [127:0] exp);
    if0.app_addr = a; if0.app_cmd = 3'b001; if0.app_en = 1'b1;
    chk("rd0_rdy", 128'(if0.app_rdy), 128'(1));
    q0.push_back('{exp, cyc + 4});
    tick();
    if0.app_en = 1'b0;
  endtask

  task automatic wait_calib();
    for (int t = 0; t < 40 && !if0.init_calib_complete; t++)
      tick();
    chk("calib_wait", 128'(if0.init_calib_complete), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q4.delete();
    tick();
    tick();
    chk("rst_outs", 128'({if0.app_rdy, if0.app_wdf_rdy, err0,
        if0.init_calib_complete, if0.app_rd_data_valid}), 128'(0));
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{27'h40, {16{8'hA5}}, 16'h0000, {16{8'hA5}}};
    tbl[1] = '{27'h80, {16{8'h11}}, 16'h0000, {16{8'h11}}};
    tbl[2] = '{27'h80, {16{8'h22}}, 16'h00FF,
               {{8{8'h22}}, {8{8'h11}}}};
    tbl[3] = '{27'h48, 128'h0123456789ABCDEF_FEDCBA9876543210,
               16'h0000, 128'h0123456789ABCDEF_FEDCBA9876543210};
    tbl[4] = '{27'h48, 128'h0, 16'hFFF0,
               128'h0123456789ABCDEF_FEDCBA98_00000000};
    tbl[5] = '{27'h00, {16{8'h3C}}, 16'h0000, {16{8'h3C}}};

    if0.app_addr = '0; if0.app_cmd = '0; if0.app_en = 1'b0;
    if0.app_wdf_data = '0; if0.app_wdf_end = 1'b1;
    if0.app_wdf_wren = 1'b0; if0.app_wdf_mask = '0;
    if0.app_sr_req = 1'b0; if0.app_ref_req = 1'b0;
    if0.app_zq_req = 1'b0;
    if4.app_addr = '0; if4.app_cmd = '0; if4.app_en = 1'b0;
    if4.app_wdf_data = '0; if4.app_wdf_end = 1'b1;
    if4.app_wdf_wren = 1'b0; if4.app_wdf_mask = '0;
    if4.app_sr_req = 1'b0; if4.app_ref_req = 1'b0;
    if4.app_zq_req = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rdy", 128'({if0.app_rdy, if0.app_wdf_rdy}), 128'(0));
    chk("rst_rd", 128'({if0.app_rd_data_valid,
        if0.app_rd_data_end}), 128'(0));
    chk("rst_data", if0.app_rd_data, 128'(0));
    chk("rst_calib", 128'(if0.init_calib_complete), 128'(0));
    chk("rst_err", 128'(err0), 128'(0));
    chk("rst_cnt", 128'({wc0, rc0}), 128'(0));
    chk("rst_tie", 128'({if0.app_sr_active, if0.app_ref_ack,
        if0.app_zq_ack}), 128'(0));
    rst = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("calib0", 128'(if0.init_calib_complete), 128'(k == 16));
      chk("calib4", 128'(if4.init_calib_complete), 128'(k == 16));
      if (k < 16) chk("rdy_precal", 128'(if0.app_rdy), 128'(0));
    end

    for (int i = 0; i < 6; i++) begin
      wr0(tbl[i].a, tbl[i].d, tbl[i].m);
      rd0(tbl[i].a, tbl[i].exp);
    end
    repeat (6) tick();
    chk("tbl_wc", 128'(wc0), 128'(6));
    chk("tbl_rc", 128'(rc0), 128'(6));

    if0.app_wdf_data = {8{16'hDEAD}}; if0.app_wdf_mask = '0;
    if0.app_wdf_wren = 1'b1;
    chk("df_wdf_rdy", 128'(if0.app_wdf_rdy), 128'(1));
    tick();
    if0.app_wdf_wren = 1'b0;
    chk("df_hold", 128'({if0.app_wdf_rdy, if0.app_rdy}),
        128'(2'b01));
    repeat (2) tick();
    chk("df_hold2", 128'(if0.app_wdf_rdy), 128'(0));
    if0.app_addr = 27'h100; if0.app_cmd = 3'b000;
    if0.app_en = 1'b1;
    tick();
    if0.app_en = 1'b0;
    chk("df_free", 128'(if0.app_wdf_rdy), 128'(1));
    chk("df_wc", 128'(wc0), 128'(7));
    rd0(27'h100, {8{16'hDEAD}});

    if0.app_addr = 27'h108; if0.app_cmd = 3'b000;
    if0.app_en = 1'b1;
    tick();
    if0.app_en = 1'b0;
    chk("cf_hold", 128'({if0.app_rdy, if0.app_wdf_rdy}),
        128'(2'b01));
    repeat (2) tick();
    chk("cf_hold2", 128'(if0.app_rdy), 128'(0));
    chk("cf_wc_wait", 128'(wc0), 128'(7));
    if0.app_wdf_data = {8{16'hCAFE}}; if0.app_wdf_wren = 1'b1;
    tick();
    if0.app_wdf_wren = 1'b0;
    chk("cf_free", 128'(if0.app_rdy), 128'(1));
    chk("cf_wc", 128'(wc0), 128'(8));
    rd0(27'h108, {8{16'hCAFE}});
    repeat (5) tick();
    chk("err_clean", 128'(err0), 128'(0));

    rd0(27'h8000, 128'(0));
    repeat (5) tick();
    chk("err_oor_rd", 128'(err0), 128'(1));
    wr0(27'h8000, {16{8'hFF}}, 16'h0000);
    rd0(27'h0, {16{8'h3C}});
    repeat (6) tick();
    chk("oor_wc", 128'(wc0), 128'(9));
    chk("oor_rc", 128'(rc0), 128'(10));

    rd0(27'h40, {16{8'hA5}});
    rd0(27'h80, {{8{8'h22}}, {8{8'h11}}});
    do_reset();
    repeat (8) tick();
    chk("post_rst_err", 128'(err0), 128'(0));
    chk("post_rst_cnt", 128'({wc0, rc0}), 128'(0));
    wait_calib();
    rd0(27'h40, {16{8'hA5}});
    chk("unk_err_pre", 128'(err0), 128'(0));
    if0.app_cmd = 3'b010; if0.app_en = 1'b1;
    tick();
    if0.app_en = 1'b0;
    chk("unk_err", 128'(err0), 128'(1));
    repeat (6) tick();
    chk("retain_rc", 128'(rc0), 128'(1));

    do_reset();
    wait_calib();
    chk("end_err_pre", 128'(err0), 128'(0));
    if0.app_wdf_end = 1'b0;
    wr0(27'h10, {4{32'h600DF00D}}, 16'h0000);
    if0.app_wdf_end = 1'b1;
    chk("end_err", 128'(err0), 128'(1));
    chk("end_wc", 128'(wc0), 128'(1));
    rd0(27'h10, {4{32'h600DF00D}});

    for (int i = 0; i < 8; i++) begin
      if4.app_addr = 27'(i << 3); if4.app_cmd = 3'b000;
      if4.app_wdf_data = d4(i); if4.app_wdf_mask = '0;
      if4.app_en = 1'b1; if4.app_wdf_wren = 1'b1;
      for (int t = 0; t < 10 &&
           !(if4.app_rdy && if4.app_wdf_rdy); t++)
        tick();
      tick();
      if4.app_en = 1'b0; if4.app_wdf_wren = 1'b0;
    end
    chk("b2b_wc", 128'(wc4), 128'(8));

    begin
      int acc;
      int bad;
      logic hist[$];
      acc = 0;
      bad = 0;
      if4.app_cmd = 3'b001;
      if4.app_en = 1'b1;
      for (int t = 0; t < 40 && acc < 8; t++) begin
        if4.app_addr = 27'(acc << 3);
        hist.push_back(if4.app_rdy);
        if (if4.app_rdy) begin
          q4.push_back('{d4(acc), cyc + 4});
          acc++;
        end
        tick();
      end
      if4.app_en = 1'b0;
      chk("b2b_acc", 128'(acc), 128'(8));
      for (int i = 0; i + 4 <= hist.size(); i++) begin
        int lows;
        lows = 0;
        for (int j = 0; j < 4; j++) if (!hist[i+j]) lows++;
        if (lows != 1) bad++;
      end
      chk("stall_pat", 128'(bad), 128'(0));
      chk("stall_seen", 128'(hist.size() >= 10), 128'(1));
    end
    repeat (8) tick();
    chk("b2b_rc", 128'(rc4), 128'(8));
    chk("q0_empty", 128'(q0.size()), 128'(0));
    chk("q4_empty", 128'(q4.size()), 128'(0));
    chk("end_rc", 128'(rc0), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
Synthesizable, BRAM-backed stand-in for the DDR3 memory-interface IP user interface (UI). It is the responder side of the app_* command, write-data and read-data channels. It accepts commands from a traffic generator, emulates calibration delay, ready back-pressure and fixed-latency in-order read returns, and lets the camera/HDMI frame-buffer path be tested in simulation and on-chip without DDR. Memory is an array of 128-bit words.

Parameters:
DEPTH_WORDS, 4096, number of 128-bit words stored; word index = app_addr >> ADDR_LSB.
ADDR_LSB, 3, right shift applied to app_addr to form the word index.
CALIB_CYCLES, 16, cycles after reset release before init_calib_complete rises (>=1).
RD_LATENCY, 4, cycles from read-command acceptance to app_rd_data_valid (>=1).
RDY_PERIOD, 0, stall injection: 0 = never stall; N>=2 = app_rdy and app_wdf_rdy forced low one cycle in every N.

Ports:
clk_in  input  1  UI clock
rst_in  input  1  synchronous active-high reset
app_addr  input  27  command address
app_cmd  input  3  000 write, 001 read
app_en  input  1  command valid
app_wdf_data  input  128  write data
app_wdf_end  input  1  last beat of write data (always 1; single-beat bursts)
app_wdf_wren  input  1  write data valid
app_wdf_mask  input  16  byte mask; 1 = byte NOT written
app_rdy  output  1  command ready
app_wdf_rdy  output  1  write data ready
app_rd_data  output  128  read data
app_rd_data_end  output  1  equals app_rd_data_valid
app_rd_data_valid  output  1  read data valid; no back-pressure
init_calib_complete  output  1  calibration done
app_sr_req, app_ref_req, app_zq_req  input  1 each  ignored
app_sr_active, app_ref_ack, app_zq_ack  output  1 each  tied 0
err_out  output  1  sticky protocol/range error
wr_count_out  output  32  committed writes
rd_count_out  output  32  returned reads

Behaviour:
- Reset: all outputs 0. The calibration counter, stall counter, pending registers, read pipeline and counters are cleared. Memory contents are retained. Reset mid-operation drops in-flight reads; no valid data is issued for them.
- Calibration: init_calib_complete rises exactly CALIB_CYCLES cycles after the first cycle with rst_in low, then stays high. Before that, app_rdy = app_wdf_rdy = 0.
- Stall counter: free-runs 0..RDY_PERIOD-1 once calibration is complete. stall = (RDY_PERIOD>=2 && cnt == RDY_PERIOD-1).
- app_rdy = calib && ~stall && ~wcmd_pend.
- app_wdf_rdy = calib && ~stall && ~wdata_held.
- Command accepted when app_en && app_rdy. Write data accepted when app_wdf_wren && app_wdf_rdy.
- Write pairing:
  - A write command and write data may arrive in either order.
  - One-entry command holding register (wcmd_pend) and one-entry data holding register (wdata_held, including mask).
  - A write commits in the cycle both are available: held+new, new+held, or same cycle.
  - On commit, unmasked bytes are written and wr_count_out increments.
  - Data accepted while no command is pending is held. A command accepted while no data is available is held.
  - app_wdf_wren with app_wdf_end=0 sets err_out; the beat is still treated as complete.
- Reads:
  - Accepted read samples memory at acceptance (after any commit in the same cycle).
  - app_rd_data_valid/app_rd_data_end pulse exactly RD_LATENCY cycles later, strictly in order. Back-to-back accepts give back-to-back returns.
  - rd_count_out increments per returned word.
  - Because app_rdy is low while a write command is pending, reads always observe every previously accepted write.
- Range: index >= DEPTH_WORDS sets err_out. An out-of-range write is dropped but still counted as committed. An out-of-range read returns all-zero data, still with valid.
- Unknown app_cmd: accepted, no effect, sets err_out.
- err_out clears only on reset. Counters wrap modulo 2^32.

Test Plan:
- Reset, CALIB_CYCLES=16 -> init_calib_complete rises on 16th cycle after rst_in falls; app_rdy=0 before; all outputs 0 during reset.
- Same-cycle write to app_addr=0x40 with data 0xA5..A5, mask 0, then read 0x40 -> app_rd_data=0xA5..A5 exactly 4 cycles after read accept; wr_count_out=1, rd_count_out=1.
- Data-first then command 3 cycles later (and command-first variant) -> app_wdf_rdy low while data is held, app_rdy low while command is held; single commit; readback correct.
- Mask 16'h00FF over word 0x11..11 writing 0x22..22 -> readback upper 8 bytes 0x22, lower 8 bytes 0x11.
- 8 back-to-back reads of words 0..7 with RDY_PERIOD=4 -> ready low every 4th cycle; returns in order, each exactly RD_LATENCY after its accept.
- Read word 4096, app_cmd=3'b010, then rst_in pulse with 2 reads in flight -> zero data returned for the out-of-range read, err_out=1, no valid after reset, err_out cleared.
